// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the multi-player game core.
//   game_state_e : round state encoding (IDLE=0, PLAY=1, ROUND_OVER=2)
//   H_ACTIVE/V_ACTIVE : visible raster size in pixels
//   rgb_t()      : extract one channel (0=red, 1=green, 2=blue) from a packed colour
package game_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPlay      = 2'd1,
        StRoundOver = 2'd2
    } game_state_e;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    // Red occupies the most significant channel, blue the least significant.
    function automatic logic [31:0] rgb_t(input logic [95:0] color,
                                          input int unsigned color_bits,
                                          input int unsigned chan);
        int unsigned cw;
        int unsigned shamt;
        logic [95:0] mask;
        cw    = color_bits / 3;
        shamt = color_bits - (chan + 1) * cw;
        mask  = (96'd1 << cw) - 96'd1;
        return 32'((color >> shamt) & mask);
    endfunction

endpackage

// File: rtl/game_core_mp_input.sv
// player_input_cond: per-player control conditioning.
//   clk_i, rst_ni    : pixel clock, asynchronous active-low reset
//   frame_start_i    : one-cycle pulse per frame, latches the controls
//   play_i           : high while the round is in PLAY; outputs are zero otherwise
//   move_raw_i[3:0]  : asynchronous direction buttons
//   shoot_raw_i      : asynchronous fire button
//   move_o[3:0]      : frame-stable direction
//   shoot_o          : high for one frame after a fire-button press
module player_input_cond (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_start_i,
    input  logic       play_i,
    input  logic [3:0] move_raw_i,
    input  logic       shoot_raw_i,
    output logic [3:0] move_o,
    output logic       shoot_o
);

    logic [3:0] move_meta_q, move_sync_q, move_lat_q;
    logic       shoot_meta_q, shoot_sync_q, shoot_last_q, shoot_pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            move_meta_q   <= 4'b0;
            move_sync_q   <= 4'b0;
            move_lat_q    <= 4'b0;
            shoot_meta_q  <= 1'b0;
            shoot_sync_q  <= 1'b0;
            shoot_last_q  <= 1'b0;
            shoot_pulse_q <= 1'b0;
        end else begin
            move_meta_q  <= move_raw_i;
            move_sync_q  <= move_meta_q;
            shoot_meta_q <= shoot_raw_i;
            shoot_sync_q <= shoot_meta_q;
            if (frame_start_i) begin
                // Edge history keeps running outside PLAY so a button held across
                // round start does not fire on the first frame.
                move_lat_q    <= move_sync_q;
                shoot_pulse_q <= shoot_sync_q & ~shoot_last_q;
                shoot_last_q  <= shoot_sync_q;
            end
        end
    end

    assign move_o  = play_i ? move_lat_q : 4'b0;
    assign shoot_o = play_i & shoot_pulse_q;

endmodule

// File: rtl/game_core_mp.sv
// game_core_mp: N-player round control, scoring and pixel compositor.
//   clk_i, reset_i        : pixel clock, asynchronous active-low reset
//   frame_start_i         : one pulse per frame
//   display_enable_i, hpos_i, vpos_i : video timing in
//   start_i, player_move_i, player_shoot_i : asynchronous raw controls
//   map/player/bullet *_enable_i, *_rgb_i : layer inputs (player k at slice k)
//   hit_valid_i, hit_shooter_i, hit_victim_i : at most one hit event per cycle
//   player_move_o, player_shoot_o : frame-latched controls, zero outside PLAY
//   game_state_o, score_o, winner_o : round status
//   display_enable_o, hpos_o, vpos_o, red_o, green_o, blue_o : one-cycle delayed video
module game_core_mp
    import game_pkg::*;
#(
    parameter  int unsigned N_PLAYERS        = 2,
    parameter  int unsigned COLOR_BITS       = 24,
    parameter  int unsigned SCORE_W          = 4,
    parameter  int unsigned SCORE_TO_WIN     = 5,
    parameter  int unsigned ROUND_END_FRAMES = 120,
    parameter  int unsigned BORDER_PX        = 8,
    localparam int unsigned PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
    localparam int unsigned CW = COLOR_BITS / 3
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            frame_start_i,
    input  logic                            display_enable_i,
    input  logic [9:0]                      hpos_i,
    input  logic [9:0]                      vpos_i,
    input  logic                            start_i,
    input  logic [N_PLAYERS*4-1:0]          player_move_i,
    input  logic [N_PLAYERS-1:0]            player_shoot_i,
    input  logic                            map_enable_i,
    input  logic [COLOR_BITS-1:0]           map_rgb_i,
    input  logic [N_PLAYERS-1:0]            player_enable_i,
    input  logic [N_PLAYERS*COLOR_BITS-1:0] player_rgb_i,
    input  logic [N_PLAYERS-1:0]            bullet_enable_i,
    input  logic [N_PLAYERS*COLOR_BITS-1:0] bullet_rgb_i,
    input  logic                            hit_valid_i,
    input  logic [PW-1:0]                   hit_shooter_i,
    input  logic [PW-1:0]                   hit_victim_i,
    output logic [N_PLAYERS*4-1:0]          player_move_o,
    output logic [N_PLAYERS-1:0]            player_shoot_o,
    output logic [1:0]                      game_state_o,
    output logic [N_PLAYERS*SCORE_W-1:0]    score_o,
    output logic [PW-1:0]                   winner_o,
    output logic                            display_enable_o,
    output logic [9:0]                      hpos_o,
    output logic [9:0]                      vpos_o,
    output logic [CW-1:0]                   red_o,
    output logic [CW-1:0]                   green_o,
    output logic [CW-1:0]                   blue_o
);

    localparam int unsigned    CNT_W     = $clog2(ROUND_END_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUND_END_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(SCORE_TO_WIN);
    localparam logic [PW:0]    N_LIMIT   = (PW + 1)'(N_PLAYERS);
    localparam logic [9:0]     BORDER_LO = 10'(BORDER_PX);
    localparam logic [9:0]     H_HI      = 10'(H_ACTIVE - BORDER_PX);
    localparam logic [9:0]     V_HI      = 10'(V_ACTIVE - BORDER_PX);

    game_state_e        state_q;
    logic [SCORE_W-1:0] score_q [N_PLAYERS];
    logic [PW-1:0]      winner_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic               start_meta_q, start_sync_q, start_last_q;

    logic               start_rise;
    logic               hit_ok;
    logic [SCORE_W-1:0] shooter_score;
    logic               play;

    assign play       = (state_q == StPlay);
    assign start_rise = start_sync_q & ~start_last_q;
    assign hit_ok     = hit_valid_i && (hit_shooter_i != hit_victim_i) &&
                        ({1'b0, hit_shooter_i} < N_LIMIT) &&
                        ({1'b0, hit_victim_i} < N_LIMIT);
    assign shooter_score = score_q[hit_shooter_i];

    // Control conditioning, one instance per player.
    for (genvar k = 0; k < N_PLAYERS; k++) begin : g_player
        player_input_cond u_cond (
            .clk_i         (clk_i),
            .rst_ni        (reset_i),
            .frame_start_i (frame_start_i),
            .play_i        (play),
            .move_raw_i    (player_move_i[k*4 +: 4]),
            .shoot_raw_i   (player_shoot_i[k]),
            .move_o        (player_move_o[k*4 +: 4]),
            .shoot_o       (player_shoot_o[k])
        );
        assign score_o[k*SCORE_W +: SCORE_W] = score_q[k];
    end

    assign game_state_o = state_q;
    assign winner_o     = winner_q;

    // Round state machine with scores, winner and round-over frame counter.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= StIdle;
            winner_q     <= '0;
            frame_cnt_q  <= '0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_last_q <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
        end else begin
            start_meta_q <= start_i;
            start_sync_q <= start_meta_q;
            start_last_q <= start_sync_q;
            unique case (state_q)
                StIdle: begin
                    if (start_rise) begin
                        for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
                        winner_q <= '0;
                        state_q  <= StPlay;
                    end
                end
                StPlay: begin
                    if (hit_ok && (shooter_score != WIN_SCORE)) begin
                        score_q[hit_shooter_i] <= shooter_score + 1'b1;
                        if (shooter_score + 1'b1 == WIN_SCORE) begin
                            winner_q    <= hit_shooter_i;
                            frame_cnt_q <= '0;
                            state_q     <= StRoundOver;
                        end
                    end
                end
                StRoundOver: begin
                    if (frame_start_i) begin
                        if (frame_cnt_q == CNT_LAST) begin
                            state_q <= StIdle;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Layer priority: lowest-index enabled bullet, then player, then map.
    logic                  in_border;
    logic                  bullet_any, player_any;
    logic [COLOR_BITS-1:0] bullet_col, player_col, pix_d;

    assign in_border = (hpos_i < BORDER_LO) || (hpos_i >= H_HI) ||
                       (vpos_i < BORDER_LO) || (vpos_i >= V_HI);

    always_comb begin
        bullet_any = 1'b0;
        bullet_col = '0;
        player_any = 1'b0;
        player_col = '0;
        // Scan high to low so the lowest enabled index is the last one written.
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (bullet_enable_i[k]) begin
                bullet_any = 1'b1;
                bullet_col = bullet_rgb_i[k*COLOR_BITS +: COLOR_BITS];
            end
            if (player_enable_i[k]) begin
                player_any = 1'b1;
                player_col = player_rgb_i[k*COLOR_BITS +: COLOR_BITS];
            end
        end
        if (!display_enable_i) begin
            pix_d = '0;
        end else if ((state_q == StRoundOver) && in_border) begin
            pix_d = '1;
        end else if (bullet_any) begin
            pix_d = bullet_col;
        end else if (player_any) begin
            pix_d = player_col;
        end else if (map_enable_i) begin
            pix_d = map_rgb_i;
        end else begin
            pix_d = '0;
        end
    end

    // Single register stage keeps timing and colour aligned.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            display_enable_o <= 1'b0;
            hpos_o           <= 10'd0;
            vpos_o           <= 10'd0;
            red_o            <= '0;
            green_o          <= '0;
            blue_o           <= '0;
        end else begin
            display_enable_o <= display_enable_i;
            hpos_o           <= hpos_i;
            vpos_o           <= vpos_i;
            red_o            <= CW'(rgb_t(96'(pix_d), COLOR_BITS, 0));
            green_o          <= CW'(rgb_t(96'(pix_d), COLOR_BITS, 1));
            blue_o           <= CW'(rgb_t(96'(pix_d), COLOR_BITS, 2));
        end
    end

endmodule

// File: tb/tb_game_core_mp.sv
// Testbench for game_core_mp with four players: a frame/round-level reference
// model checked every cycle, plus literal expectations at key points.
module tb_game_core_mp;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_start = 1'b0;
    logic        de = 1'b0;
    logic [9:0]  hpos = 10'd0, vpos = 10'd0;
    logic        start = 1'b0;
    logic [15:0] move_raw = 16'h0;
    logic [3:0]  shoot_raw = 4'h0;
    logic        map_en = 1'b0;
    logic [23:0] map_rgb = 24'h123456;
    logic [3:0]  pl_en = 4'h0, bl_en = 4'h0;
    logic [95:0] pl_rgb, bl_rgb;
    logic        hit_v = 1'b0;
    logic [1:0]  hit_s = 2'd0, hit_vi = 2'd0;

    logic [15:0] move_o;
    logic [3:0]  shoot_o;
    logic [1:0]  state_o;
    logic [15:0] score_o;
    logic [1:0]  winner_o;
    logic        de_o;
    logic [9:0]  hpos_o, vpos_o;
    logic [7:0]  red_o, green_o, blue_o;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    game_core_mp #(
        .N_PLAYERS        (4),
        .COLOR_BITS       (24),
        .SCORE_W          (4),
        .SCORE_TO_WIN     (5),
        .ROUND_END_FRAMES (120),
        .BORDER_PX        (8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_n),
        .frame_start_i    (frame_start),
        .display_enable_i (de),
        .hpos_i           (hpos),
        .vpos_i           (vpos),
        .start_i          (start),
        .player_move_i    (move_raw),
        .player_shoot_i   (shoot_raw),
        .map_enable_i     (map_en),
        .map_rgb_i        (map_rgb),
        .player_enable_i  (pl_en),
        .player_rgb_i     (pl_rgb),
        .bullet_enable_i  (bl_en),
        .bullet_rgb_i     (bl_rgb),
        .hit_valid_i      (hit_v),
        .hit_shooter_i    (hit_s),
        .hit_victim_i     (hit_vi),
        .player_move_o    (move_o),
        .player_shoot_o   (shoot_o),
        .game_state_o     (state_o),
        .score_o          (score_o),
        .winner_o         (winner_o),
        .display_enable_o (de_o),
        .hpos_o           (hpos_o),
        .vpos_o           (vpos_o),
        .red_o            (red_o),
        .green_o          (green_o),
        .blue_o           (blue_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state, m_winner, m_frames;
    int          m_score [N];
    logic [3:0]  m_move [N];
    logic        m_pulse [N];
    logic        m_last [N];
    logic [20:0] hist [3];   // {start, shoot[3:0], move[15:0]} raw samples, newest first
    logic        e_de;
    logic [9:0]  e_h, e_v;
    logic [23:0] e_col;

    function automatic logic [23:0] expect_colour();
        if (!de) return 24'h0;
        if (m_state == 2 && (hpos < 8 || hpos >= 632 || vpos < 8 || vpos >= 472))
            return 24'hFFFFFF;
        for (int k = 0; k < N; k++) if (bl_en[k]) return bl_rgb[24*k +: 24];
        for (int k = 0; k < N; k++) if (pl_en[k]) return pl_rgb[24*k +: 24];
        if (map_en) return map_rgb;
        return 24'h0;
    endfunction

    task automatic model_step();
        logic [20:0] sy, pr;
        if (!reset_n) begin
            m_state = 0; m_winner = 0; m_frames = 0;
            for (int k = 0; k < N; k++) begin
                m_score[k] = 0; m_move[k] = 4'h0; m_pulse[k] = 1'b0; m_last[k] = 1'b0;
            end
            for (int i = 0; i < 3; i++) hist[i] = 21'h0;
            e_de = 1'b0; e_h = 10'd0; e_v = 10'd0; e_col = 24'h0;
        end else begin
            // Synchronised value seen now is the raw input from two edges ago.
            sy = hist[1];
            pr = hist[2];
            e_de = de; e_h = hpos; e_v = vpos; e_col = expect_colour();
            if (frame_start) begin
                for (int k = 0; k < N; k++) begin
                    m_move[k]  = sy[4*k +: 4];
                    m_pulse[k] = sy[16+k] & ~m_last[k];
                    m_last[k]  = sy[16+k];
                end
            end
            case (m_state)
                0: if (sy[20] && !pr[20]) begin
                    for (int k = 0; k < N; k++) m_score[k] = 0;
                    m_winner = 0;
                    m_state = 1;
                end
                1: if (hit_v && hit_s != hit_vi) begin
                    if (m_score[hit_s] < 5) m_score[hit_s]++;
                    if (m_score[hit_s] == 5) begin
                        m_winner = int'(hit_s); m_frames = 0; m_state = 2;
                    end
                end
                default: if (frame_start) begin
                    m_frames++;
                    if (m_frames == 120) m_state = 0;
                end
            endcase
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {start, shoot_raw, move_raw};
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [15:0] x_move, x_score;
        logic [3:0]  x_shoot;
        @(negedge clk);
        if (run) begin
            for (int k = 0; k < N; k++) begin
                x_move[4*k +: 4] = (m_state == 1) ? m_move[k] : 4'h0;
                x_shoot[k]       = (m_state == 1) ? m_pulse[k] : 1'b0;
                x_score[4*k +: 4] = 4'(m_score[k]);
            end
            check("state", 32'(state_o), 32'(m_state));
            check("winner", 32'(winner_o), 32'(m_winner));
            check("score", 32'(score_o), 32'(x_score));
            check("move", 32'(move_o), 32'(x_move));
            check("shoot", 32'(shoot_o), 32'(x_shoot));
            check("de_o", 32'(de_o), 32'(e_de));
            check("hpos_o", 32'(hpos_o), 32'(e_h));
            check("vpos_o", 32'(vpos_o), 32'(e_v));
            check("rgb", {8'h0, red_o, green_o, blue_o}, {8'h0, e_col});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic hit(input logic [1:0] s, input logic [1:0] v);
        hit_v = 1'b1; hit_s = s; hit_vi = v;
        tick();
        hit_v = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] h, input logic [9:0] v);
        hpos = h; vpos = v;
        tick();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pl_rgb[24*k +: 24] = 24'hA0B0C0 + 24'(k);
            bl_rgb[24*k +: 24] = 24'h102030 + 24'(k);
        end
        #2 reset_n = 1'b0;
        #1 run = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_score", 32'(score_o), 32'd0);
        check("reset_rgb", {8'h0, red_o, green_o, blue_o}, 32'd0);

        // Start: PLAY after the third edge, not before.
        start = 1'b1;
        tick(); tick();
        check("start_not_yet", 32'(state_o), 32'd0);
        tick();
        check("start_play", 32'(state_o), 32'd1);
        check("start_scores", 32'(score_o), 32'd0);
        start = 1'b0;

        // Player 2 holds shoot and move 0100 across three frames.
        shoot_raw[2] = 1'b1;
        move_raw[11:8] = 4'b0100;
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("shoot2_first", 32'(shoot_o[2]), 32'd1);
        check("move2_latched", 32'(move_o[11:8]), 32'h4);
        tick();
        frame();
        check("shoot2_second", 32'(shoot_o[2]), 32'd0);
        frame();
        check("shoot2_third", 32'(shoot_o[2]), 32'd0);
        check("move2_held", 32'(move_o[11:8]), 32'h4);
        shoot_raw = 4'h0;
        move_raw = 16'h0;
        repeat (3) tick();
        frame();

        // Scoring: four hits, a self-hit, then the winning hit.
        repeat (4) hit(2'd1, 2'd0);
        check("score1_four", 32'(score_o[7:4]), 32'd4);
        check("still_play", 32'(state_o), 32'd1);
        hit(2'd1, 2'd1);
        check("self_hit", 32'(score_o[7:4]), 32'd4);
        hit(2'd1, 2'd0);
        check("score1_win", 32'(score_o[7:4]), 32'd5);
        check("round_over", 32'(state_o), 32'd2);
        check("winner", 32'(winner_o), 32'd1);

        // ROUND_OVER border and interior pixels.
        de = 1'b1; map_en = 1'b1;
        pixel(10'd3, 10'd100);
        check("border_white", {8'h0, red_o, green_o, blue_o}, 32'h00FFFFFF);
        pixel(10'd100, 10'd100);
        check("interior_map", {8'h0, red_o, green_o, blue_o}, 32'h00123456);
        pixel(10'd631, 10'd200);
        pixel(10'd632, 10'd200);
        pixel(10'd100, 10'd7);
        pixel(10'd100, 10'd8);
        pixel(10'd100, 10'd471);
        pixel(10'd100, 10'd472);
        hit(2'd2, 2'd3);
        check("ro_hit_ignored", 32'(score_o), 32'h0050);

        repeat (119) frame();
        check("ro_119", 32'(state_o), 32'd2);
        frame();
        check("idle_120", 32'(state_o), 32'd0);
        check("score_held", 32'(score_o[7:4]), 32'd5);
        hit(2'd0, 2'd1);
        check("idle_hit_ignored", 32'(score_o[3:0]), 32'd0);

        // Compositor priority in IDLE.
        bl_en = 4'b1000; pl_en = 4'b0001;
        pixel(10'd3, 10'd100);
        check("bullet3", {8'h0, red_o, green_o, blue_o}, 32'h00102033);
        de = 1'b0;
        tick();
        check("blank", {8'h0, red_o, green_o, blue_o}, 32'd0);
        de = 1'b1; bl_en = 4'b0110;
        tick();
        check("bullet1", {8'h0, red_o, green_o, blue_o}, 32'h00102031);
        bl_en = 4'b0000; pl_en = 4'b0110;
        tick();
        check("player1", {8'h0, red_o, green_o, blue_o}, 32'h00A0B0C1);
        pl_en = 4'b0000;
        tick();

        // New round, then reset mid-PLAY.
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        check("replay", 32'(state_o), 32'd1);
        check("replay_cleared", 32'(score_o), 32'd0);
        repeat (3) hit(2'd0, 2'd2);
        check("score0_three", 32'(score_o[3:0]), 32'd3);
        check("rgb_before_reset", {8'h0, red_o, green_o, blue_o}, 32'h00123456);
        #2 reset_n = 1'b0;
        #1;
        check("async_score", 32'(score_o), 32'd0);
        check("async_state", 32'(state_o), 32'd0);
        check("async_rgb", {8'h0, red_o, green_o, blue_o}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
